// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one i2c_master_top request/ack port between
// NUM_REQ requester FSMs; latches the winner's fields and routes ack/data/error back.
module i2c_req_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     rq_read_req,
  input  logic [NUM_REQ-1:0]     rq_write_req,
  input  logic [8*NUM_REQ-1:0]   rq_dev_addr,
  input  logic [16*NUM_REQ-1:0]  rq_reg_addr,
  input  logic [NUM_REQ-1:0]     rq_addr_2byte,
  input  logic [8*NUM_REQ-1:0]   rq_write_data,
  output logic [NUM_REQ-1:0]     rq_ack,
  output logic [7:0]             rq_read_data,
  output logic                   rq_error,
  output logic [1:0]             grant_idx,
  output logic                   busy,
  output logic                   m_read_req,
  output logic                   m_write_req,
  input  logic                   m_read_req_ack,
  input  logic                   m_write_req_ack,
  output logic [7:0]             m_dev_addr,
  output logic [15:0]            m_reg_addr,
  output logic                   m_addr_2byte,
  output logic [7:0]             m_write_data,
  input  logic [7:0]             m_read_data,
  input  logic                   m_error
);

  // state | meaning
  // IDLE  | searching for a pending requester from rr_ptr
  // BUSY  | request issued to master, waiting for matching ack
  // ACK   | one-cycle rq_ack pulse to the winner
  // GAP   | requests ignored so the winner can drop its req
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [1:0]         state;
  logic [1:0]         rr_ptr;
  logic [3:0]         pending;
  logic [2:0]         cand;
  logic               found;
  logic [1:0]         win_idx;
  logic [7:0]         sel_dev;
  logic [15:0]        sel_reg;
  logic               sel_2byte;
  logic [7:0]         sel_wdata;
  logic               sel_write;
  logic [NUM_REQ-1:0] ack_vec;
  logic [1:0]         next_ptr;
  logic               done;

  always_comb begin
    pending = '0;
    pending[NUM_REQ-1:0] = rq_read_req | rq_write_req;
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + 3'(i);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (!found && pending[cand[1:0]]) begin
        found   = 1'b1;
        win_idx = cand[1:0];
      end
    end
  end

  always_comb begin
    sel_dev   = '0;
    sel_reg   = '0;
    sel_2byte = 1'b0;
    sel_wdata = '0;
    sel_write = 1'b0;
    ack_vec   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == 2'(k)) begin
        sel_dev   = rq_dev_addr[8*k +: 8];
        sel_reg   = rq_reg_addr[16*k +: 16];
        sel_2byte = rq_addr_2byte[k];
        sel_wdata = rq_write_data[8*k +: 8];
        sel_write = rq_write_req[k];
      end
      ack_vec[k] = (grant_idx == 2'(k));
    end
  end

  assign next_ptr = (grant_idx == 2'(NUM_REQ-1)) ? 2'd0 : grant_idx + 2'd1;
  // Only the ack type that matches the issued request completes the transaction.
  assign done = (m_write_req && m_write_req_ack) || (m_read_req && m_read_req_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      grant_idx    <= '0;
      busy         <= 1'b0;
      m_read_req   <= 1'b0;
      m_write_req  <= 1'b0;
      m_dev_addr   <= 8'h00;
      m_reg_addr   <= '0;
      m_addr_2byte <= 1'b0;
      m_write_data <= '0;
      rq_ack       <= '0;
      rq_read_data <= '0;
      rq_error     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            m_dev_addr   <= sel_dev;
            m_reg_addr   <= sel_reg;
            m_addr_2byte <= sel_2byte;
            m_write_data <= sel_wdata;
            grant_idx    <= win_idx;
            busy         <= 1'b1;
            m_write_req  <= sel_write;
            m_read_req   <= !sel_write;
            state        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (done) begin
            m_read_req  <= 1'b0;
            m_write_req <= 1'b0;
            if (m_read_req) rq_read_data <= m_read_data;
            rq_error    <= m_error;
            rq_ack      <= ack_vec;
            rr_ptr      <= next_ptr;
            state       <= ST_ACK;
          end
        end
        ST_ACK: begin
          rq_ack <= '0;
          state  <= ST_GAP;
        end
        ST_GAP: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
